bsg_level_shift_iso_ctrl: RTL and testbench

- Isolation and handshake controller for one voltage-domain crossing.
- Sequences the isolation enable driven into the level-shift source gates (v0 side), with settle and drain timing.
- Captures the gated data returning on the v1 side into a 2-entry buffer with a valid/yumi output interface.
- Sits directly upstream of the level-shift gates (drives their enable) and directly downstream of them (consumes their data).

---
 rtl/bsg_level_shift_iso_ctrl.sv | 121 ++++++++++++
 tb/tb_bsg_level_shift_iso_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bsg_level_shift_iso_ctrl.sv
// Isolation sequencer and 2-entry capture buffer for one voltage-domain crossing.
// Drives the level-shift gate enable (v0 side) and buffers gated data arriving on the v1 side.
module bsg_level_shift_iso_ctrl #(
  parameter int width_p         = 32,
  parameter int settle_cycles_p = 8,
  parameter int drain_cycles_p  = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pwr_req_i,
  output logic               pwr_ack_o,
  output logic               v0_en_o,
  input  logic               v1_v_i,
  input  logic [width_p-1:0] v1_data_i,
  output logic               v1_ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int cnt_max_lp = (settle_cycles_p > drain_cycles_p) ? settle_cycles_p - 1
                                                                  : drain_cycles_p - 1;
  localparam int cnt_w_lp   = (cnt_max_lp < 2) ? 1 : $clog2(cnt_max_lp + 1);

  typedef enum logic [1:0] {OFF, SETTLE, ON, DRAIN} state_e;

  state_e              state, state_n;
  logic [cnt_w_lp-1:0] counter, counter_n;
  logic                en_n, ack_n;

  // State register; enable and ack are flopped alongside so they never glitch at the gates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= OFF;
      counter   <= '0;
      v0_en_o   <= 1'b0;
      pwr_ack_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state     <= state_n;
      counter   <= counter_n;
      v0_en_o   <= en_n;
      pwr_ack_o <= ack_n;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    state_n   = state;
    counter_n = counter;
    unique case (state)
      OFF: begin
        if (pwr_req_i) begin
          state_n   = SETTLE;
          counter_n = cnt_w_lp'(settle_cycles_p - 1);
        end
      end
      SETTLE: begin
        if (!pwr_req_i)            state_n   = OFF;
        else if (counter == '0)    state_n   = ON;
        else                       counter_n = counter - cnt_w_lp'(1);
      end
      ON: begin
        if (!pwr_req_i) begin
          state_n   = DRAIN;
          counter_n = cnt_w_lp'(drain_cycles_p - 1);
        end
      end
      DRAIN: begin
        if (counter == '0) state_n   = OFF;
        else               counter_n = counter - cnt_w_lp'(1);
      end
      default: state_n = OFF;
    endcase
  end

  always_comb begin
    en_n  = (state_n == ON);
    ack_n = (state_n == ON) || (state_n == DRAIN);
  end

  // Capture buffer: survives DRAIN/OFF so the consumer can empty it while powered down.
  logic [width_p-1:0] mem [2];
  logic               head, tail;
  logic [1:0]         count;
  logic               enq, deq;

  assign v1_ready_o = (state == ON) && (count < 2'd2);
  assign v_o        = (count != 2'd0);
  assign data_o     = v_o ? mem[head] : '0;
  assign enq        = v1_v_i && v1_ready_o;
  assign deq        = yumi_i && v_o;

  // NOTE: storage is not reset; data_o is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (enq) mem[tail] <= v1_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      unique case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted with empty buffer");

  assert property (@(posedge clk_i) disable iff (reset_i) !(v1_v_i && state != ON && !v0_en_o))
    else $error("v1_v_i high while gates are isolated");

endmodule

// File: tb/tb_bsg_level_shift_iso_ctrl.sv
// Directed power sequencing plus randomized ON-state traffic against a queue-based buffer model.
module tb_bsg_level_shift_iso_ctrl;
  localparam int W = 32;
  localparam int S = 8;
  localparam int D = 4;

  logic         clk_i = 1'b0;
  logic         reset_i, pwr_req_i, v1_v_i, yumi_i;
  logic [W-1:0] v1_data_i;
  logic         pwr_ack_o, v0_en_o, v1_ready_o, v_o;
  logic [W-1:0] data_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q[$];

  always #5 clk_i = ~clk_i;

  bsg_level_shift_iso_ctrl #(.width_p(W), .settle_cycles_p(S), .drain_cycles_p(D)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pwr_req_i(pwr_req_i), .pwr_ack_o(pwr_ack_o),
    .v0_en_o(v0_en_o), .v1_v_i(v1_v_i), .v1_data_i(v1_data_i), .v1_ready_o(v1_ready_o),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic en, input logic ack, input logic rdy,
                           input logic v, input logic [W-1:0] d);
    check({tag, ".en"},    W'(v0_en_o),    W'(en));
    check({tag, ".ack"},   W'(pwr_ack_o),  W'(ack));
    check({tag, ".ready"}, W'(v1_ready_o), W'(rdy));
    check({tag, ".v"},     W'(v_o),        W'(v));
    check({tag, ".data"},  data_o,         d);
  endtask

  // Advance one edge and settle just past it; outputs are sampled and inputs driven here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit           rv, ry, rdy_m;
    logic [W-1:0] rd;

    reset_i = 1'b1; pwr_req_i = 1'b0; v1_v_i = 1'b0; yumi_i = 1'b0; v1_data_i = '0;
    step(); step();
    check_all("reset", 0, 0, 0, 0, '0);
    reset_i = 1'b0;
    step();
    check_all("off_idle", 0, 0, 0, 0, '0);

    // Aborted settle: request high for 3 edges, then dropped.
    pwr_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_en", W'(v0_en_o), '0);
      check("abort_ack", W'(pwr_ack_o), '0);
    end
    pwr_req_i = 1'b0;
    for (int i = 0; i < S + 2; i++) begin
      step();
      check("abort_off_en", W'(v0_en_o), '0);
      check("abort_off_ack", W'(pwr_ack_o), '0);
    end

    // Full power-up: edges 0..S-1 stay isolated, enable rises after edge S.
    pwr_req_i = 1'b1;
    for (int e = 0; e <= S; e++) begin
      step();
      check($sformatf("pu_en_e%0d", e), W'(v0_en_o), W'(e == S));
      check($sformatf("pu_ack_e%0d", e), W'(pwr_ack_o), W'(e == S));
    end
    check_all("on_empty", 1, 1, 1, 0, '0);

    // Fill to two entries, third word refused, then drain in order.
    v1_v_i = 1'b1; v1_data_i = 32'hA5A5A5A5;
    step();
    check_all("fill1", 1, 1, 1, 1, 32'hA5A5A5A5);
    v1_data_i = 32'h5A5A5A5A;
    step();
    check_all("fill2", 1, 1, 0, 1, 32'hA5A5A5A5);
    v1_data_i = 32'hDEADBEEF;
    step();
    check_all("full_hold", 1, 1, 0, 1, 32'hA5A5A5A5);
    v1_v_i = 1'b0; yumi_i = 1'b1;
    step();
    check_all("deq1", 1, 1, 1, 1, 32'h5A5A5A5A);
    step();
    check_all("deq2", 1, 1, 1, 0, '0);
    yumi_i = 1'b0;

    // Simultaneous enqueue/dequeue at one entry.
    v1_v_i = 1'b1; v1_data_i = 32'h1;
    step();
    check_all("sim_pre", 1, 1, 1, 1, 32'h1);
    v1_data_i = 32'h2; yumi_i = 1'b1;
    step();
    check_all("sim_post", 1, 1, 1, 1, 32'h2);
    v1_v_i = 1'b0;
    step();
    check_all("sim_empty", 1, 1, 1, 0, '0);
    yumi_i = 1'b0;

    // Randomized traffic while powered, checked against a FIFO queue.
    q.delete();
    for (int i = 0; i < 300; i++) begin
      check("rnd_v", W'(v_o), W'(q.size() != 0));
      check("rnd_data", data_o, (q.size() != 0) ? q[0] : '0);
      check("rnd_ready", W'(v1_ready_o), W'(q.size() < 2));
      rdy_m = (q.size() < 2);
      rv = 1'($urandom_range(0, 1));
      rd = $urandom;
      ry = (q.size() != 0) && ($urandom_range(0, 2) != 0);
      v1_v_i = rv; v1_data_i = rd; yumi_i = ry;
      step();
      if (ry) void'(q.pop_front());
      if (rv && rdy_m) q.push_back(rd);
    end
    v1_v_i = 1'b0;
    while (q.size() != 0) begin
      yumi_i = 1'b1;
      step();
      void'(q.pop_front());
    end
    yumi_i = 1'b0;
    check_all("rnd_end", 1, 1, 1, 0, '0);

    // Power-down with one word buffered; re-request during drain is deferred to OFF.
    v1_v_i = 1'b1; v1_data_i = 32'h3;
    step();
    v1_v_i = 1'b0;
    check_all("pd_pre", 1, 1, 1, 1, 32'h3);
    for (int i = 0; i <= D + 1 + S; i++) begin
      if (i == 0)     pwr_req_i = 1'b0;
      if (i == 1)     pwr_req_i = 1'b1;
      if (i == D + 1) yumi_i = 1'b1;
      if (i == D + 2) yumi_i = 1'b0;
      step();
      check($sformatf("pd_en_k%0d", i), W'(v0_en_o), W'(i == D + 1 + S));
      check($sformatf("pd_ack_k%0d", i), W'(pwr_ack_o), W'((i < D) || (i == D + 1 + S)));
      check($sformatf("pd_ready_k%0d", i), W'(v1_ready_o), W'(i == D + 1 + S));
      check($sformatf("pd_v_k%0d", i), W'(v_o), W'(i <= D));
      check($sformatf("pd_data_k%0d", i), data_o, (i <= D) ? 32'h3 : '0);
    end

    // Async reset while ON with a full buffer.
    v1_v_i = 1'b1; v1_data_i = 32'h11;
    step();
    v1_data_i = 32'h22;
    step();
    v1_v_i = 1'b0;
    check_all("rst_pre", 1, 1, 0, 1, 32'h11);
    #3;
    reset_i = 1'b1; pwr_req_i = 1'b0;
    #1;
    check_all("rst_async", 0, 0, 0, 0, '0);
    step(); step();
    reset_i = 1'b0;
    step();
    check_all("rst_off", 0, 0, 0, 0, '0);
    pwr_req_i = 1'b1;
    for (int e = 0; e <= S; e++) step();
    check_all("rst_reon_empty", 1, 1, 1, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
